// File: rtl/packet_assembler.sv
// packet_assembler: rebuilds a PACKET_WIDTH-byte packet from the demodulated serial
// bit stream (LSB-first per byte, byte 0 first) and holds it until acknowledged.
module packet_assembler #(
    parameter int PACKET_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         bit_in_i,
    input  logic                         bit_valid_i,
    input  logic                         packet_ack_i,
    output logic [PACKET_WIDTH-1:0][7:0] packet_o,
    output logic                         packet_valid_o,
    output logic                         busy_o,
    output logic                         overrun_o
);
    localparam int NB = PACKET_WIDTH * 8;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d, wr_pos;
    logic [NB-1:0]                  buf_q, buf_d;
    logic [PACKET_WIDTH-1:0][7:0]   pkt_q, pkt_d;
    logic                           valid_q, valid_d, ovr_q, ovr_d, accept, done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // A start pulse restarts at bit 0, and a bit arriving with it is that bit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        pkt_d   = pkt_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        wr_pos  = start_i ? '0 : cnt_q;
        accept  = bit_valid_i && (start_i || state_q == COLLECT);
        done    = accept && wr_pos == CW'(NB - 1);
        if (start_i) begin
            state_d = COLLECT;
            cnt_d   = '0;
            buf_d   = '0;
        end
        if (accept) begin
            for (int k = 0; k < NB; k++)
                if (wr_pos == CW'(k)) buf_d[k] = bit_in_i;
            cnt_d = wr_pos + 1'b1;
        end
        if (valid_q && packet_ack_i) valid_d = 1'b0;
        // Completing while the previous packet is still unacked drops the new one.
        if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (valid_q && !packet_ack_i) begin
                ovr_d = 1'b1;
            end else begin
                pkt_d   = buf_d;
                valid_d = 1'b1;
            end
        end
    end

    assign packet_o       = pkt_q;
    assign packet_valid_o = valid_q;
    assign busy_o         = state_q == COLLECT;
    assign overrun_o      = ovr_q;
endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: directed scenarios for packet_assembler with PACKET_WIDTH=4.
module tb_packet_assembler;
    localparam int PW = 4;

    logic clk_i = 1'b0, rst_ni = 1'b1, start_i = 1'b0, bit_in_i = 1'b0;
    logic bit_valid_i = 1'b0, packet_ack_i = 1'b0;
    logic [PW-1:0][7:0] packet_o;
    logic packet_valid_o, busy_o, overrun_o;
    int total = 0, bad = 0;

    packet_assembler #(.PACKET_WIDTH(PW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .bit_in_i(bit_in_i),
        .bit_valid_i(bit_valid_i), .packet_ack_i(packet_ack_i), .packet_o(packet_o),
        .packet_valid_o(packet_valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int lo, input int hi, input bit with_start);
        for (int i = lo; i < hi; i++) begin
            start_i     = with_start && i == lo;
            bit_valid_i = 1'b1;
            bit_in_i    = v[i];
            tick();
        end
        start_i     = 1'b0;
        bit_valid_i = 1'b0;
        bit_in_i    = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if ({packet_o, packet_valid_o, busy_o, overrun_o} !== 35'd0) begin
            bad++;
            $display("FAIL reset: outputs=%h expected 0", {packet_o, packet_valid_o, busy_o, overrun_o});
        end
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        tick();
        total++;
        if ({packet_valid_o, busy_o} !== 2'b00) begin
            bad++;
            $display("FAIL reset_release: valid,busy=%b expected 00", {packet_valid_o, busy_o});
        end
    endtask

    task automatic test_basic;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        send_bits(32'h01FF3CA5, 0, 31, 1'b0);
        total++;
        if ({busy_o, packet_valid_o} !== 2'b10) begin
            bad++;
            $display("FAIL basic_pre_last: busy,valid=%b expected 10", {busy_o, packet_valid_o});
        end
        send_bits(32'h01FF3CA5, 31, 32, 1'b0);
        total++;
        if ({packet_valid_o, busy_o, overrun_o} !== 3'b100 || packet_o !== 32'h01FF3CA5) begin
            bad++;
            $display("FAIL basic_done: valid,busy,ovr=%b packet=%h expected 100 01ff3ca5",
                     {packet_valid_o, busy_o, overrun_o}, packet_o);
        end
    endtask

    task automatic test_hold_ack;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (!packet_valid_o || packet_o !== 32'h01FF3CA5) begin
                bad++;
                $display("FAIL hold_%0d: valid=%b packet=%h expected 1 01ff3ca5", i, packet_valid_o, packet_o);
            end
        end
        packet_ack_i = 1'b1;
        tick();
        packet_ack_i = 1'b0;
        total++;
        if (packet_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL ack_drop: valid=%b expected 0", packet_valid_o);
        end
    endtask

    task automatic test_overrun;
        send_bits(32'h01FF3CA5, 0, 32, 1'b1);
        send_bits(32'h33221100, 0, 32, 1'b1);
        total++;
        if ({packet_valid_o, overrun_o} !== 2'b11 || packet_o !== 32'h01FF3CA5) begin
            bad++;
            $display("FAIL overrun_pulse: valid,ovr=%b packet=%h expected 11 01ff3ca5",
                     {packet_valid_o, overrun_o}, packet_o);
        end
        tick();
        total++;
        if (overrun_o !== 1'b0 || packet_o !== 32'h01FF3CA5) begin
            bad++;
            $display("FAIL overrun_one_cycle: ovr=%b packet=%h expected 0 01ff3ca5", overrun_o, packet_o);
        end
        send_bits(32'h33221100, 0, 31, 1'b1);
        packet_ack_i = 1'b1;
        send_bits(32'h33221100, 31, 32, 1'b0);
        packet_ack_i = 1'b0;
        total++;
        if ({packet_valid_o, overrun_o} !== 2'b10 || packet_o !== 32'h33221100) begin
            bad++;
            $display("FAIL ack_on_completion: valid,ovr=%b packet=%h expected 10 33221100",
                     {packet_valid_o, overrun_o}, packet_o);
        end
        packet_ack_i = 1'b1;
        tick();
        packet_ack_i = 1'b0;
    endtask

    task automatic test_restart;
        send_bits(32'h5A5A5A5A, 0, 13, 1'b1);
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL restart_busy: busy=%b expected 1", busy_o);
        end
        send_bits(32'hEFBEADDE, 0, 32, 1'b1);
        total++;
        if ({packet_valid_o, overrun_o, busy_o} !== 3'b100 || packet_o !== 32'hEFBEADDE) begin
            bad++;
            $display("FAIL restart_packet: valid,ovr,busy=%b packet=%h expected 100 efbeadde",
                     {packet_valid_o, overrun_o, busy_o}, packet_o);
        end
        packet_ack_i = 1'b1;
        tick();
        packet_ack_i = 1'b0;
    endtask

    task automatic test_idle_bits;
        for (int i = 0; i < 5; i++) begin
            bit_valid_i = 1'b1;
            bit_in_i    = i[0];
            tick();
            total++;
            if ({busy_o, packet_valid_o} !== 2'b00) begin
                bad++;
                $display("FAIL idle_bit_%0d: busy,valid=%b expected 00", i, {busy_o, packet_valid_o});
            end
        end
        bit_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        send_bits(32'hC3965A81, 0, 32, 1'b0);
        total++;
        if (packet_valid_o !== 1'b1 || packet_o !== 32'hC3965A81) begin
            bad++;
            $display("FAIL idle_then_packet: valid=%b packet=%h expected 1 c3965a81", packet_valid_o, packet_o);
        end
    endtask

    task automatic test_async_reset;
        send_bits(32'hFFFFFFFF, 0, 20, 1'b1);
        bit_valid_i = 1'b1;
        bit_in_i    = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if ({packet_o, packet_valid_o, busy_o, overrun_o} !== 35'd0) begin
            bad++;
            $display("FAIL async_reset: outputs=%h expected 0", {packet_o, packet_valid_o, busy_o, overrun_o});
        end
        bit_valid_i = 1'b0;
        bit_in_i    = 1'b0;
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        tick();
        send_bits(32'h12345678, 0, 32, 1'b1);
        total++;
        if ({packet_valid_o, busy_o, overrun_o} !== 3'b100 || packet_o !== 32'h12345678) begin
            bad++;
            $display("FAIL after_reset_packet: valid,busy,ovr=%b packet=%h expected 100 12345678",
                     {packet_valid_o, busy_o, overrun_o}, packet_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_ack();
        test_overrun();
        test_restart();
        test_idle_bits();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
